// File: rtl/audio_mix_stream.sv
// N-channel streaming PCM mixer: per-channel sample FIFOs drained once per sample tick,
// scaled by per-channel L/R gain, summed, saturated and presented as one stereo pair.
module audio_mix_stream #(
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 256,
    parameter  int SW       = 16,
    parameter  int VW       = 8,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   smp_tick,
    input  logic                   wr_req,
    input  logic [CW-1:0]          wr_ch,
    input  logic [SW-1:0]          wr_dat,
    input  logic                   vol_we,
    input  logic [CW-1:0]          vol_ch,
    input  logic [VW-1:0]          vol_l,
    input  logic [VW-1:0]          vol_r,
    input  logic [CHANNELS-1:0]    ch_en,
    input  logic                   flag_clr,
    output logic [CHANNELS*LW-1:0] level,
    output logic [CHANNELS-1:0]    full,
    output logic [CHANNELS-1:0]    underrun,
    output logic [CHANNELS-1:0]    overflow,
    output logic                   tick_miss,
    output logic [SW-1:0]          snd_l,
    output logic [SW-1:0]          snd_r,
    output logic                   snd_vld
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = SW + VW + 1;
    localparam int ACCW = SW + VW + CW + 1;

    localparam logic signed [ACCW-1:0] SAT_MAX = $signed({{(ACCW-SW+1){1'b0}}, {(SW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] SAT_MIN = $signed({{(ACCW-SW+1){1'b1}}, {(SW-1){1'b0}}});
    localparam logic [VW-1:0]          VOL_UNITY = {1'b1, {(VW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        MAC_LAST = 2'd2,
        SAT      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;

    logic fetch_act;
    logic acc_clr;
    logic sat_en;
    logic miss_set;

    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] push_ok;
    logic [CHANNELS-1:0] under_set;
    logic [CHANNELS-1:0] over_set;

    logic [SW-1:0] rd_arr    [CHANNELS];
    logic [VW-1:0] vol_l_arr [CHANNELS];
    logic [VW-1:0] vol_r_arr [CHANNELS];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (smp_tick) begin
                    state_d = FETCH;
                    ch_d    = '0;
                end
            end
            FETCH: begin
                if (ch_q == CW'(CHANNELS - 1)) begin
                    state_d = MAC_LAST;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            MAC_LAST: state_d = SAT;
            SAT:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_act = (state_q == FETCH);
        acc_clr   = (state_q == IDLE) && smp_tick;
        sat_en    = (state_q == SAT);
        miss_set  = (state_q != IDLE) && smp_tick;
    end

    // ---------------------------------------------------------------- per-channel FIFO and gains
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SW-1:0] mem [DEPTH];
        logic [AW-1:0] wr_ptr_q, rd_ptr_q;
        logic [LW-1:0] level_q, level_d;
        logic [SW-1:0] rd_q;
        logic [VW-1:0] vol_l_q, vol_r_q;
        logic          sel_fetch;
        logic          push_req;

        assign sel_fetch     = fetch_act && (ch_q == CW'(gi)) && ch_en[gi];
        assign pop[gi]       = sel_fetch && (level_q != '0);
        assign under_set[gi] = sel_fetch && (level_q == '0);
        assign push_req      = wr_req && (wr_ch == CW'(gi));
        assign full[gi]      = (level_q == LW'(DEPTH));
        assign push_ok[gi]   = push_req && !full[gi];
        assign over_set[gi]  = push_req && full[gi];

        always_ff @(posedge clk) begin
            if (push_ok[gi]) begin
                mem[wr_ptr_q] <= wr_dat;
            end
            if (pop[gi]) begin
                rd_q <= mem[rd_ptr_q];
            end
        end

        always_comb begin
            level_d = level_q;
            if (push_ok[gi] && !pop[gi]) begin
                level_d = level_q + LW'(1);
            end else if (!push_ok[gi] && pop[gi]) begin
                level_d = level_q - LW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_ok[gi]) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                level_q <= level_d;
            end
        end

        // A gain written mid-mix is picked up by any channel whose MAC slot is still ahead.
        always_ff @(posedge clk) begin
            if (rst) begin
                vol_l_q <= VOL_UNITY;
                vol_r_q <= VOL_UNITY;
            end else if (vol_we && (vol_ch == CW'(gi))) begin
                vol_l_q <= vol_l;
                vol_r_q <= vol_r;
            end
        end

        assign rd_arr[gi]              = rd_q;
        assign vol_l_arr[gi]           = vol_l_q;
        assign vol_r_arr[gi]           = vol_r_q;
        assign level[gi*LW +: LW]      = level_q;
    end

    // ---------------------------------------------------------------- MAC stage, one cycle behind FETCH
    logic          mac_vld_q;
    logic          mac_pop_q;
    logic [CW-1:0] mac_ch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_vld_q <= 1'b0;
            mac_pop_q <= 1'b0;
            mac_ch_q  <= '0;
        end else begin
            mac_vld_q <= fetch_act;
            mac_pop_q <= |pop;
            mac_ch_q  <= ch_q;
        end
    end

    logic [SW-1:0]          mac_smp;
    logic [VW-1:0]          mac_vl, mac_vr;
    logic signed [PW-1:0]   smp_x, vl_x, vr_x;
    logic signed [PW-1:0]   prod_l, prod_r;
    logic signed [ACCW-1:0] acc_l_q, acc_l_d;
    logic signed [ACCW-1:0] acc_r_q, acc_r_d;

    assign mac_smp = mac_pop_q ? rd_arr[mac_ch_q] : '0;
    assign mac_vl  = vol_l_arr[mac_ch_q];
    assign mac_vr  = vol_r_arr[mac_ch_q];
    assign smp_x   = $signed({{(PW-SW){mac_smp[SW-1]}}, mac_smp});
    assign vl_x    = $signed({{(PW-VW){1'b0}}, mac_vl});
    assign vr_x    = $signed({{(PW-VW){1'b0}}, mac_vr});
    assign prod_l  = smp_x * vl_x;
    assign prod_r  = smp_x * vr_x;

    always_comb begin
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (acc_clr) begin
            acc_l_d = '0;
            acc_r_d = '0;
        end else if (mac_vld_q) begin
            acc_l_d = acc_l_q + $signed({{(ACCW-PW){prod_l[PW-1]}}, prod_l});
            acc_r_d = acc_r_q + $signed({{(ACCW-PW){prod_r[PW-1]}}, prod_r});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
        end
    end

    // ---------------------------------------------------------------- saturation and output
    function automatic logic [SW-1:0] clamp_s(input logic signed [ACCW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SW-1:0];
        end
        return v[SW-1:0];
    endfunction

    logic signed [ACCW-1:0] sh_l, sh_r;
    logic [SW-1:0]          snd_l_q, snd_r_q;
    logic                   snd_vld_q;

    assign sh_l = acc_l_q >>> (VW - 1);
    assign sh_r = acc_r_q >>> (VW - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            snd_l_q   <= '0;
            snd_r_q   <= '0;
            snd_vld_q <= 1'b0;
        end else begin
            snd_vld_q <= sat_en;
            if (sat_en) begin
                snd_l_q <= clamp_s(sh_l);
                snd_r_q <= clamp_s(sh_r);
            end
        end
    end

    // ---------------------------------------------------------------- sticky flags, set beats clear
    logic [CHANNELS-1:0] underrun_q, overflow_q;
    logic                tick_miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q  <= '0;
            overflow_q  <= '0;
            tick_miss_q <= 1'b0;
        end else begin
            underrun_q  <= (underrun_q & ~{CHANNELS{flag_clr}}) | under_set;
            overflow_q  <= (overflow_q & ~{CHANNELS{flag_clr}}) | over_set;
            tick_miss_q <= (tick_miss_q & ~flag_clr) | miss_set;
        end
    end

    assign underrun  = underrun_q;
    assign overflow  = overflow_q;
    assign tick_miss = tick_miss_q;
    assign snd_l     = snd_l_q;
    assign snd_r     = snd_r_q;
    assign snd_vld   = snd_vld_q;

endmodule

// File: tb/tb_audio_mix_stream.sv
// Self-checking bench for audio_mix_stream: directed scenarios plus randomized mixes
// checked against a queue-based arithmetic model of the mixer.
module tb_audio_mix_stream;

    localparam int CH    = 4;
    localparam int DEPTH = 256;
    localparam int SW    = 16;
    localparam int VW    = 8;
    localparam int LW    = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic                smp_tick;
    logic                wr_req;
    logic [1:0]          wr_ch;
    logic [SW-1:0]       wr_dat;
    logic                vol_we;
    logic [1:0]          vol_ch;
    logic [VW-1:0]       vol_l;
    logic [VW-1:0]       vol_r;
    logic [CH-1:0]       ch_en;
    logic                flag_clr;
    logic [CH*LW-1:0]    level;
    logic [CH-1:0]       full;
    logic [CH-1:0]       underrun;
    logic [CH-1:0]       overflow;
    logic                tick_miss;
    logic [SW-1:0]       snd_l;
    logic [SW-1:0]       snd_r;
    logic                snd_vld;

    always #5 clk = ~clk;

    audio_mix_stream #(.CHANNELS(CH), .DEPTH(DEPTH), .SW(SW), .VW(VW)) dut (
        .clk(clk), .rst(rst), .smp_tick(smp_tick), .wr_req(wr_req), .wr_ch(wr_ch),
        .wr_dat(wr_dat), .vol_we(vol_we), .vol_ch(vol_ch), .vol_l(vol_l), .vol_r(vol_r),
        .ch_en(ch_en), .flag_clr(flag_clr), .level(level), .full(full),
        .underrun(underrun), .overflow(overflow), .tick_miss(tick_miss),
        .snd_l(snd_l), .snd_r(snd_r), .snd_vld(snd_vld)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int            q_m [CH][$];
    int            vol_l_m [CH];
    int            vol_r_m [CH];
    logic [CH-1:0] und_m;
    logic [CH-1:0] ovf_m;
    logic          tm_m;

    function automatic int sat_model(input longint acc);
        longint s;
        s = acc >>> (VW - 1);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            q_m[c].delete();
            vol_l_m[c] = 128;
            vol_r_m[c] = 128;
        end
        und_m = '0;
        ovf_m = '0;
        tm_m  = 1'b0;
    endtask

    task automatic model_clear_flags();
        und_m = '0;
        ovf_m = '0;
        tm_m  = 1'b0;
    endtask

    task automatic model_mix(input logic [CH-1:0] en, output int l, output int r);
        longint al, ar;
        int     s;
        al = 0;
        ar = 0;
        for (int c = 0; c < CH; c++) begin
            if (en[c]) begin
                if (q_m[c].size() > 0) begin
                    s = q_m[c].pop_front();
                end else begin
                    s = 0;
                    und_m[c] = 1'b1;
                end
                al += longint'(s) * vol_l_m[c];
                ar += longint'(s) * vol_r_m[c];
            end
        end
        l = sat_model(al);
        r = sat_model(ar);
    endtask

    // ---------------------------------------------------------------- stimulus drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input int ch, input int dat);
        logic signed [SW-1:0] d;
        d      = SW'(dat);
        wr_req = 1'b1;
        wr_ch  = 2'(ch);
        wr_dat = d;
        step();
        wr_req = 1'b0;
        if (q_m[ch].size() >= DEPTH) ovf_m[ch] = 1'b1;
        else q_m[ch].push_back(int'(d));
    endtask

    task automatic set_vol(input int ch, input int l, input int r);
        vol_we = 1'b1;
        vol_ch = 2'(ch);
        vol_l  = VW'(l);
        vol_r  = VW'(r);
        step();
        vol_we     = 1'b0;
        vol_l_m[ch] = l;
        vol_r_m[ch] = r;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        model_clear_flags();
    endtask

    // Pulses smp_tick and watches a bounded window; lat is the cycle of the first snd_vld.
    task automatic run_tick(output int lat, output int l, output int r, output int nv);
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        lat = -1; l = 0; r = 0; nv = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (snd_vld) begin
                nv++;
                if (lat < 0) begin
                    lat = k;
                    l = int'($signed(snd_l));
                    r = int'($signed(snd_r));
                end
            end
        end
        $display("tick: en=%b lat=%0d snd_l=%0d snd_r=%0d vld_count=%0d", ch_en, lat, l, r, nv);
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (level !== '0) $display("FAIL reset_level: got %h expected 0", level);
        else n_pass++;
        n_checks++;
        if (full !== '0 || underrun !== '0 || overflow !== '0 || tick_miss !== 1'b0)
            $display("FAIL reset_flags: got full=%b und=%b ovf=%b miss=%b expected all 0",
                     full, underrun, overflow, tick_miss);
        else n_pass++;
        n_checks++;
        if (snd_l !== '0 || snd_r !== '0 || snd_vld !== 1'b0)
            $display("FAIL reset_snd: got l=%h r=%h vld=%b expected 0", snd_l, snd_r, snd_vld);
        else n_pass++;
    endtask

    task automatic test_mix_basic();
        int el, er, gl, gr, lat, nv;
        push(0, 1000);
        push(1, -300);
        ch_en = 4'b0011;
        model_mix(ch_en, el, er);
        run_tick(lat, gl, gr, nv);
        n_checks++;
        if (lat !== CH + 2) $display("FAIL basic_latency: got %0d expected %0d", lat, CH + 2);
        else n_pass++;
        n_checks++;
        if (nv !== 1) $display("FAIL basic_vld_count: got %0d expected 1", nv);
        else n_pass++;
        n_checks++;
        if (gl !== el || gr !== er)
            $display("FAIL basic_mix: got l=%0d r=%0d expected l=%0d r=%0d", gl, gr, el, er);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (int'(level[c*LW +: LW]) !== q_m[c].size())
                $display("FAIL basic_level%0d: got %0d expected %0d", c, level[c*LW +: LW], q_m[c].size());
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int el, er, gl, gr, lat, nv;
        int pats [2];
        pats[0] = 32767;
        pats[1] = -32768;
        ch_en = 4'b1111;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < CH; c++) push(c, pats[p]);
            model_mix(ch_en, el, er);
            run_tick(lat, gl, gr, nv);
            n_checks++;
            if (gl !== el || gr !== er)
                $display("FAIL saturate_%0d: got l=%0d r=%0d expected l=%0d r=%0d", p, gl, gr, el, er);
            else n_pass++;
        end
    endtask

    task automatic test_volume();
        int el, er, gl, gr, lat, nv;
        set_vol(2, 'h40, 'h00);
        push(2, 2000);
        ch_en = 4'b0100;
        model_mix(ch_en, el, er);
        run_tick(lat, gl, gr, nv);
        n_checks++;
        if (gl !== el || gr !== er)
            $display("FAIL volume_ch2: got l=%0d r=%0d expected l=%0d r=%0d", gl, gr, el, er);
        else n_pass++;
        set_vol(2, 128, 128);

        // Gain change for ch1 lands before ch1's MAC slot, so the new gain applies.
        push(0, 1000);
        push(1, 1000);
        ch_en = 4'b0011;
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        vol_we = 1'b1; vol_ch = 2'd1; vol_l = 8'd0; vol_r = 8'd128;
        step();
        vol_we = 1'b0;
        vol_l_m[1] = 0;
        vol_r_m[1] = 128;
        model_mix(ch_en, el, er);
        lat = -1; gl = 0; gr = 0;
        for (int k = 2; k <= 12; k++) begin
            step();
            if (snd_vld && lat < 0) begin
                lat = k;
                gl = int'($signed(snd_l));
                gr = int'($signed(snd_r));
            end
        end
        $display("tick: mid-mix gain change lat=%0d snd_l=%0d snd_r=%0d", lat, gl, gr);
        n_checks++;
        if (lat !== CH + 2 || gl !== el || gr !== er)
            $display("FAIL volume_midmix: got lat=%0d l=%0d r=%0d expected lat=%0d l=%0d r=%0d",
                     lat, gl, gr, CH + 2, el, er);
        else n_pass++;
        set_vol(1, 128, 128);
    endtask

    task automatic test_push_pop();
        int el, er, gl, gr, lat, nv;
        int a, b, c3;
        a  = int'($signed(16'($urandom)));
        b  = int'($signed(16'($urandom)));
        c3 = int'($signed(16'($urandom)));
        push(1, a);
        push(1, b);
        ch_en = 4'b0010;
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        step();
        // This cycle is ch1's FETCH slot: push and pop coincide.
        wr_req = 1'b1; wr_ch = 2'd1; wr_dat = 16'(c3);
        step();
        wr_req = 1'b0;
        model_mix(ch_en, el, er);
        q_m[1].push_back(c3);
        n_checks++;
        if (int'(level[1*LW +: LW]) !== q_m[1].size())
            $display("FAIL pushpop_level: got %0d expected %0d", level[1*LW +: LW], q_m[1].size());
        else n_pass++;
        repeat (8) step();
        for (int t = 0; t < 2; t++) begin
            model_mix(ch_en, el, er);
            run_tick(lat, gl, gr, nv);
            n_checks++;
            if (gl !== el || gr !== er)
                $display("FAIL pushpop_order%0d: got l=%0d r=%0d expected l=%0d r=%0d", t, gl, gr, el, er);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) push(3, int'($urandom));
        n_checks++;
        if (full[3] !== (q_m[3].size() == DEPTH) || int'(level[3*LW +: LW]) !== q_m[3].size())
            $display("FAIL overflow_full: got full=%b level=%0d expected full=%b level=%0d",
                     full[3], level[3*LW +: LW], q_m[3].size() == DEPTH, q_m[3].size());
        else n_pass++;
        n_checks++;
        if (overflow !== ovf_m) $display("FAIL overflow_flag: got %b expected %b", overflow, ovf_m);
        else n_pass++;
        // Clear coincident with another push to the full FIFO: the set wins.
        flag_clr = 1'b1;
        model_clear_flags();
        push(3, 1);
        flag_clr = 1'b0;
        n_checks++;
        if (overflow !== ovf_m) $display("FAIL overflow_set_wins: got %b expected %b", overflow, ovf_m);
        else n_pass++;
        pulse_clr();
        n_checks++;
        if (overflow !== ovf_m) $display("FAIL overflow_clear: got %b expected %b", overflow, ovf_m);
        else n_pass++;
    endtask

    task automatic test_underrun();
        int el, er, gl, gr, lat, nv;
        pulse_clr();
        ch_en = 4'b0001;
        model_mix(ch_en, el, er);
        run_tick(lat, gl, gr, nv);
        n_checks++;
        if (underrun !== und_m) $display("FAIL underrun_flag: got %b expected %b", underrun, und_m);
        else n_pass++;
        n_checks++;
        if (gl !== el || nv !== 1)
            $display("FAIL underrun_output: got l=%0d vld=%0d expected l=%0d vld=1", gl, nv, el);
        else n_pass++;
    endtask

    task automatic test_tick_miss_and_abort();
        int el, er, gl, nv;
        push(0, 1234);
        ch_en = 4'b0001;
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        step();
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        tm_m = 1'b1;
        model_mix(ch_en, el, er);
        nv = 0; gl = 0;
        for (int k = 3; k <= 14; k++) begin
            step();
            if (snd_vld) begin
                nv++;
                gl = int'($signed(snd_l));
            end
        end
        $display("tick: double tick vld_count=%0d snd_l=%0d tick_miss=%b", nv, gl, tick_miss);
        n_checks++;
        if (nv !== 1 || gl !== el)
            $display("FAIL tickmiss_single_out: got vld=%0d l=%0d expected vld=1 l=%0d", nv, gl, el);
        else n_pass++;
        n_checks++;
        if (tick_miss !== tm_m) $display("FAIL tickmiss_flag: got %b expected %b", tick_miss, tm_m);
        else n_pass++;

        push(0, 500);
        push(1, 600);
        ch_en = 4'b1111;
        smp_tick = 1'b1;
        step();
        smp_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (snd_vld) nv++;
        end
        $display("tick: reset mid-fetch vld_count=%0d", nv);
        n_checks++;
        if (nv !== 0) $display("FAIL abort_no_vld: got %0d expected 0", nv);
        else n_pass++;
        n_checks++;
        if (level !== '0 || full !== '0 || tick_miss !== tm_m)
            $display("FAIL abort_state: got level=%h full=%b miss=%b expected 0", level, full, tick_miss);
        else n_pass++;
    endtask

    task automatic test_random();
        int el, er, gl, gr, lat, nv;
        int np;
        pulse_clr();
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < CH; c++) begin
                np = int'($urandom_range(0, 2));
                for (int j = 0; j < np; j++) push(c, int'($urandom));
            end
            if ($urandom_range(0, 1) == 1)
                set_vol(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            ch_en = 4'($urandom_range(0, 15));
            model_mix(ch_en, el, er);
            run_tick(lat, gl, gr, nv);
            n_checks++;
            if (lat !== CH + 2 || gl !== el || gr !== er)
                $display("FAIL random_mix%0d: got lat=%0d l=%0d r=%0d expected lat=%0d l=%0d r=%0d",
                         it, lat, gl, gr, CH + 2, el, er);
            else n_pass++;
            n_checks++;
            if (underrun !== und_m || overflow !== ovf_m)
                $display("FAIL random_flags%0d: got und=%b ovf=%b expected und=%b ovf=%b",
                         it, underrun, overflow, und_m, ovf_m);
            else n_pass++;
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (int'(level[c*LW +: LW]) !== q_m[c].size())
                    $display("FAIL random_level%0d_ch%0d: got %0d expected %0d",
                             it, c, level[c*LW +: LW], q_m[c].size());
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; smp_tick = 1'b0; wr_req = 1'b0; wr_ch = '0; wr_dat = '0;
        vol_we = 1'b0; vol_ch = '0; vol_l = '0; vol_r = '0; ch_en = '0; flag_clr = 1'b0;
        model_reset();
        step();
        test_reset();
        test_mix_basic();
        test_saturation();
        test_volume();
        test_push_pop();
        test_overflow();
        test_underrun();
        test_tick_miss_and_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
